// File: rtl/trophy_pkg.sv
// Shared definitions for the trophy spawn scheduler: coordinate width,
// slot index width, off-board sentinel coordinates and the FSM state enum.
package trophy_pkg;

    localparam int COORD_W = 5;
    // Wide enough for slot indices 0..6 (up to 7 trophy slots).
    localparam int IDX_W   = 3;

    // Unplaced slots are parked here. The point lies outside every legal board,
    // so it can never collide with a real player position.
    localparam logic [COORD_W-1:0] ROW_OFF = 5'd23;
    localparam logic [COORD_W-1:0] COL_OFF = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_CHECK,
        ST_COMMIT,
        ST_PLAY,
        ST_DONE
    } state_t;

endpackage

// File: rtl/trophy_collision_check.sv
// Combinational acceptance test for a trophy candidate position.
// Ports:
//   cand_r_i/cand_c_i     candidate row/column
//   player_r_i/player_c_i current player row/column
//   slot_r_i/slot_c_i     packed slot coordinates, slot k at [5k+4:5k]
//   idx_i                 slot being filled; only slots below it are compared
//   reject_o              candidate is off-board, on the player or on a placed slot
module trophy_collision_check
    import trophy_pkg::*;
#(
    parameter int N_TROPHY = 3,
    parameter int ROW_MAX  = 18,
    parameter int COL_MAX  = 26
) (
    input  logic [COORD_W-1:0]          cand_r_i,
    input  logic [COORD_W-1:0]          cand_c_i,
    input  logic [COORD_W-1:0]          player_r_i,
    input  logic [COORD_W-1:0]          player_c_i,
    input  logic [COORD_W*N_TROPHY-1:0] slot_r_i,
    input  logic [COORD_W*N_TROPHY-1:0] slot_c_i,
    input  logic [IDX_W-1:0]            idx_i,
    output logic                        reject_o
);

    localparam logic [COORD_W-1:0] ROW_LIM = COORD_W'(ROW_MAX);
    localparam logic [COORD_W-1:0] COL_LIM = COORD_W'(COL_MAX);

    always_comb begin
        reject_o = 1'b0;
        if ((cand_r_i >= ROW_LIM) || (cand_c_i >= COL_LIM)) begin
            reject_o = 1'b1;
        end
        if ((cand_r_i == player_r_i) && (cand_c_i == player_c_i)) begin
            reject_o = 1'b1;
        end
        // Slots at or above idx still hold the sentinel and are not yet placed.
        for (int j = 0; j < N_TROPHY; j++) begin
            if ((IDX_W'(j) < idx_i) &&
                (slot_r_i[j*COORD_W +: COORD_W] == cand_r_i) &&
                (slot_c_i[j*COORD_W +: COORD_W] == cand_c_i)) begin
                reject_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trophy_spawn_scheduler.sv
// Places trophies from an external random coordinate source at round start,
// then retires them as the player walks over them and flags round completion.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   game_start            one-cycle pulse that (re)starts a round from any state
//   row, column           player position
//   rnd_req               ready toward the random source (high in REQ)
//   rnd_valid, rnd_r/c    candidate handshake and coordinates
//   trophy_r, trophy_c    packed slot coordinates, slot k at [5k+4:5k]
//   trophy_alive          per-slot placed-and-not-collected flags
//   busy                  placement in progress
//   place_fail            sticky: a slot ran out of retries this round
//   all_collected         round finished, every placed trophy collected
module trophy_spawn_scheduler
    import trophy_pkg::*;
#(
    parameter int N_TROPHY  = 3,
    parameter int ROW_MAX   = 18,
    parameter int COL_MAX   = 26,
    parameter int RETRY_MAX = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        game_start,
    input  logic [COORD_W-1:0]          row,
    input  logic [COORD_W-1:0]          column,
    output logic                        rnd_req,
    input  logic                        rnd_valid,
    input  logic [COORD_W-1:0]          rnd_r,
    input  logic [COORD_W-1:0]          rnd_c,
    output logic [COORD_W*N_TROPHY-1:0] trophy_r,
    output logic [COORD_W*N_TROPHY-1:0] trophy_c,
    output logic [N_TROPHY-1:0]         trophy_alive,
    output logic                        busy,
    output logic                        place_fail,
    output logic                        all_collected
);

    localparam int RETRY_W = (RETRY_MAX < 2) ? 1 : $clog2(RETRY_MAX + 1);
    localparam logic [RETRY_W-1:0]          RETRY_LIM = RETRY_W'(RETRY_MAX);
    localparam logic [IDX_W-1:0]            LAST_IDX  = IDX_W'(N_TROPHY - 1);
    localparam logic [COORD_W*N_TROPHY-1:0] ROW_PARK  = {N_TROPHY{ROW_OFF}};
    localparam logic [COORD_W*N_TROPHY-1:0] COL_PARK  = {N_TROPHY{COL_OFF}};

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [RETRY_W-1:0]          retry_q, retry_d;
    logic [RETRY_W-1:0]          retry_inc;
    logic [COORD_W*N_TROPHY-1:0] slot_r_q, slot_r_d;
    logic [COORD_W*N_TROPHY-1:0] slot_c_q, slot_c_d;
    logic [N_TROPHY-1:0]         alive_q, alive_d;
    logic                        fail_q, fail_d;
    logic                        busy_q, done_q;
    logic [COORD_W-1:0]          cand_r_q, cand_c_q;
    logic                        reject;

    trophy_collision_check #(
        .N_TROPHY (N_TROPHY),
        .ROW_MAX  (ROW_MAX),
        .COL_MAX  (COL_MAX)
    ) u_check (
        .cand_r_i   (cand_r_q),
        .cand_c_i   (cand_c_q),
        .player_r_i (row),
        .player_c_i (column),
        .slot_r_i   (slot_r_q),
        .slot_c_i   (slot_c_q),
        .idx_i      (idx_q),
        .reject_o   (reject)
    );

    assign retry_inc = retry_q + RETRY_W'(1);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        retry_d  = retry_q;
        slot_r_d = slot_r_q;
        slot_c_d = slot_c_q;
        alive_d  = alive_q;
        fail_d   = fail_q;

        unique case (state_q)
            ST_IDLE: ;
            ST_REQ: begin
                if (rnd_valid) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (reject) begin
                    retry_d = retry_inc;
                    // Giving up leaves this and all later slots parked and dead.
                    if (retry_inc == RETRY_LIM) begin
                        fail_d  = 1'b1;
                        state_d = ST_PLAY;
                    end else begin
                        state_d = ST_REQ;
                    end
                end else begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                for (int k = 0; k < N_TROPHY; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        slot_r_d[k*COORD_W +: COORD_W] = cand_r_q;
                        slot_c_d[k*COORD_W +: COORD_W] = cand_c_q;
                        alive_d[k]                     = 1'b1;
                    end
                end
                retry_d = '0;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_PLAY;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_REQ;
                end
            end
            ST_PLAY: begin
                // Collected slots keep their coordinates; only the alive bit drops.
                for (int k = 0; k < N_TROPHY; k++) begin
                    if (alive_q[k] &&
                        (slot_r_q[k*COORD_W +: COORD_W] == row) &&
                        (slot_c_q[k*COORD_W +: COORD_W] == column)) begin
                        alive_d[k] = 1'b0;
                    end
                end
                // Uses the registered flags so DONE follows the last clear by one edge.
                if (alive_q == '0) state_d = ST_DONE;
            end
            ST_DONE: ;
            default: state_d = ST_IDLE;
        endcase

        // A restart overrides everything else, including a same-cycle collection.
        if (game_start) begin
            state_d  = ST_REQ;
            idx_d    = '0;
            retry_d  = '0;
            slot_r_d = ROW_PARK;
            slot_c_d = COL_PARK;
            alive_d  = '0;
            fail_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            retry_q  <= '0;
            slot_r_q <= ROW_PARK;
            slot_c_q <= COL_PARK;
            alive_q  <= '0;
            fail_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            retry_q  <= retry_d;
            slot_r_q <= slot_r_d;
            slot_c_q <= slot_c_d;
            alive_q  <= alive_d;
            fail_q   <= fail_d;
            // Status flags are registered from the next state so they align with it.
            busy_q   <= (state_d == ST_REQ) || (state_d == ST_CHECK) ||
                        (state_d == ST_COMMIT);
            done_q   <= (state_d == ST_DONE);
        end
    end

    // Candidate holding register; only meaningful in CHECK/COMMIT, so no reset.
    always_ff @(posedge clk) begin
        if ((state_q == ST_REQ) && rnd_valid) begin
            cand_r_q <= rnd_r;
            cand_c_q <= rnd_c;
        end
    end

    assign rnd_req       = (state_q == ST_REQ);
    assign trophy_r      = slot_r_q;
    assign trophy_c      = slot_c_q;
    assign trophy_alive  = alive_q;
    assign busy          = busy_q;
    assign place_fail    = fail_q;
    assign all_collected = done_q;

endmodule

// File: tb/tb_trophy_spawn_scheduler.sv
module tb_trophy_spawn_scheduler;

    logic        clk;
    logic        rst_n;
    logic        game_start;
    logic [4:0]  row, column;
    logic        rnd_req;
    logic        rnd_valid;
    logic [4:0]  rnd_r, rnd_c;
    logic [14:0] trophy_r, trophy_c;
    logic [2:0]  trophy_alive;
    logic        busy, place_fail, all_collected;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0] tab_r [16];
    logic [4:0] tab_c [16];
    int ncand = 0;
    int cidx  = 0;
    int cyc   = 0;

    localparam logic [14:0] R_PARK = {3{5'd23}};
    localparam logic [14:0] C_PARK = {3{5'd31}};

    trophy_spawn_scheduler #(
        .N_TROPHY (3), .ROW_MAX (18), .COL_MAX (26), .RETRY_MAX (15)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .game_start    (game_start),
        .row           (row),
        .column        (column),
        .rnd_req       (rnd_req),
        .rnd_valid     (rnd_valid),
        .rnd_r         (rnd_r),
        .rnd_c         (rnd_c),
        .trophy_r      (trophy_r),
        .trophy_c      (trophy_c),
        .trophy_alive  (trophy_alive),
        .busy          (busy),
        .place_fail    (place_fail),
        .all_collected (all_collected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] pack3(input logic [4:0] s0, input logic [4:0] s1,
                                          input logic [4:0] s2);
        return {s2, s1, s0};
    endfunction

    task automatic present();
        int i;
        i = (cidx < ncand) ? cidx : ncand - 1;
        rnd_r = tab_r[i];
        rnd_c = tab_c[i];
    endtask

    task automatic clear_cands();
        ncand = 0;
        cidx  = 0;
    endtask

    task automatic push(input logic [4:0] r, input logic [4:0] c);
        tab_r[ncand] = r;
        tab_c[ncand] = c;
        ncand++;
        present();
    endtask

    // Advance one clock; the source pops its head when a transfer happened on that edge.
    task automatic tick();
        logic xfer;
        xfer = rnd_req & rnd_valid;
        @(posedge clk);
        #1;
        if (xfer) begin
            cidx++;
            present();
        end
        cyc++;
    endtask

    task automatic start_round();
        game_start = 1'b1;
        tick();
        game_start = 1'b0;
    endtask

    task automatic wait_busy_fall(output int n);
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
    endtask

    int n;

    initial begin
        rst_n      = 1'b0;
        game_start = 1'b0;
        row        = 5'd0;
        column     = 5'd0;
        rnd_valid  = 1'b0;
        clear_cands();
        push(5'd0, 5'd0);

        repeat (2) tick();
        check("rst_alive", 32'(trophy_alive), 32'(3'b000));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_req", 32'(rnd_req), 32'(0));
        check("rst_fail", 32'(place_fail), 32'(0));
        check("rst_done", 32'(all_collected), 32'(0));
        check("rst_tr", 32'(trophy_r), 32'(R_PARK));
        check("rst_tc", 32'(trophy_c), 32'(C_PARK));
        rst_n = 1'b1;
        tick();
        check("idle_req", 32'(rnd_req), 32'(0));

        // Placement with every candidate valid.
        clear_cands();
        push(5'd3, 5'd4); push(5'd5, 5'd6); push(5'd7, 5'd8);
        rnd_valid = 1'b1;
        start_round();
        check("pl_busy_rise", 32'(busy), 32'(1));
        check("pl_req", 32'(rnd_req), 32'(1));
        wait_busy_fall(n);
        check("pl_busy_cycles", 32'(n), 32'(9));
        check("pl_tr", 32'(trophy_r), 32'(pack3(5'd3, 5'd5, 5'd7)));
        check("pl_tc", 32'(trophy_c), 32'(pack3(5'd4, 5'd6, 5'd8)));
        check("pl_alive", 32'(trophy_alive), 32'(3'b111));
        check("pl_fail", 32'(place_fail), 32'(0));

        // Collection walk.
        row = 5'd5; column = 5'd6; tick();
        check("col_a1", 32'(trophy_alive), 32'(3'b101));
        row = 5'd3; column = 5'd4; tick();
        check("col_a2", 32'(trophy_alive), 32'(3'b100));
        row = 5'd7; column = 5'd8; tick();
        check("col_a3", 32'(trophy_alive), 32'(3'b000));
        check("col_done_early", 32'(all_collected), 32'(0));
        check("col_tr_kept", 32'(trophy_r), 32'(pack3(5'd3, 5'd5, 5'd7)));
        row = 5'd0; column = 5'd0; tick();
        check("col_done", 32'(all_collected), 32'(1));
        tick();
        check("col_done_hold", 32'(all_collected), 32'(1));

        // Rejection: off-board, on player, duplicate.
        clear_cands();
        push(5'd20, 5'd4); push(5'd0, 5'd0); push(5'd3, 5'd4);
        push(5'd3, 5'd4); push(5'd9, 5'd9); push(5'd10, 5'd10);
        start_round();
        check("rj_done_clr", 32'(all_collected), 32'(0));
        check("rj_tr_park", 32'(trophy_r), 32'(R_PARK));
        wait_busy_fall(n);
        check("rj_busy_cycles", 32'(n), 32'(15));
        check("rj_tr", 32'(trophy_r), 32'(pack3(5'd3, 5'd9, 5'd10)));
        check("rj_tc", 32'(trophy_c), 32'(pack3(5'd4, 5'd9, 5'd10)));
        check("rj_alive", 32'(trophy_alive), 32'(3'b111));
        check("rj_fail", 32'(place_fail), 32'(0));

        // Retry exhaustion with a constant off-board candidate.
        clear_cands();
        push(5'd30, 5'd30);
        start_round();
        wait_busy_fall(n);
        check("ex_busy_cycles", 32'(n), 32'(30));
        check("ex_fail", 32'(place_fail), 32'(1));
        check("ex_alive", 32'(trophy_alive), 32'(3'b000));
        check("ex_done_early", 32'(all_collected), 32'(0));
        check("ex_tr", 32'(trophy_r), 32'(R_PARK));
        tick();
        check("ex_done", 32'(all_collected), 32'(1));
        check("ex_fail_sticky", 32'(place_fail), 32'(1));

        // Fresh placement, then restart while standing on a live trophy.
        clear_cands();
        push(5'd3, 5'd4); push(5'd5, 5'd6); push(5'd7, 5'd8);
        start_round();
        check("rs_fail_clr", 32'(place_fail), 32'(0));
        wait_busy_fall(n);
        check("rs_alive0", 32'(trophy_alive), 32'(3'b111));
        clear_cands();
        push(5'd3, 5'd4); push(5'd5, 5'd6); push(5'd7, 5'd8); push(5'd11, 5'd12);
        row = 5'd3; column = 5'd4;
        start_round();
        check("rs_alive_clr", 32'(trophy_alive), 32'(3'b000));
        check("rs_busy", 32'(busy), 32'(1));
        check("rs_req", 32'(rnd_req), 32'(1));
        check("rs_tr_park", 32'(trophy_r), 32'(R_PARK));
        wait_busy_fall(n);
        check("rs_busy_cycles", 32'(n), 32'(11));
        check("rs_tr", 32'(trophy_r), 32'(pack3(5'd5, 5'd7, 5'd11)));
        check("rs_tc", 32'(trophy_c), 32'(pack3(5'd6, 5'd8, 5'd12)));
        check("rs_alive", 32'(trophy_alive), 32'(3'b111));

        // Asynchronous reset while waiting in REQ with one slot placed.
        row = 5'd0; column = 5'd0;
        clear_cands();
        push(5'd1, 5'd2);
        start_round();
        repeat (3) tick();
        check("ar_alive_pre", 32'(trophy_alive), 32'(3'b001));
        check("ar_tr_pre", 32'(trophy_r), 32'(pack3(5'd1, 5'd23, 5'd23)));
        rnd_valid = 1'b0;
        tick();
        check("ar_req_pre", 32'(rnd_req), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_req", 32'(rnd_req), 32'(0));
        check("ar_busy", 32'(busy), 32'(0));
        check("ar_alive", 32'(trophy_alive), 32'(3'b000));
        check("ar_tr", 32'(trophy_r), 32'(R_PARK));
        check("ar_tc", 32'(trophy_c), 32'(C_PARK));
        check("ar_fail", 32'(place_fail), 32'(0));
        check("ar_done", 32'(all_collected), 32'(0));
        tick();
        rst_n = 1'b1;
        tick();
        check("ar_idle_req", 32'(rnd_req), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
